branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/br_pkg.sv | 26 ++
 rtl/br_fifo.sv | 55 +++++
 rtl/branch_resolver.sv | 93 +++++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared types for the branch resolver: queue entry layout, FSM states and defaults.
package br_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int XLEN_DEF  = 32;
  // Entries are stored at the widest supported PC so the struct can be shared by any XLEN.
  localparam int XLEN_MAX  = 64;

  typedef struct packed {
    logic                pred;
    logic [XLEN_MAX-1:0] target;
    logic [XLEN_MAX-1:0] fallthru;
  } br_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  // Wrong direction, or right "taken" guess with the wrong target.
  function automatic logic br_miss(input br_entry_t e, input logic taken,
                                   input logic [XLEN_MAX-1:0] act_target);
    return (e.pred != taken) | (taken & e.pred & (act_target != e.target));
  endfunction

endpackage

// File: rtl/br_fifo.sv
// In-flight branch queue: strict FIFO with wrap-around pointers and a flash clear.
module br_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  br_entry_t                wdata,
  output br_entry_t                rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  br_entry_t         mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so push+pop is legal while full.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Matches EX branch outcomes against queued predictions; drives predictor update and flush/redirect.
module branch_resolver
  import br_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_pred,
  input  logic [XLEN-1:0]        push_target,
  input  logic [XLEN-1:0]        push_fallthru,
  input  logic                   stall,
  input  logic                   resolve,
  input  logic                   taken,
  input  logic [XLEN-1:0]        act_target,
  output logic                   update,
  output logic                   outcome,
  output logic                   miss,
  output logic                   flush,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   error
);

  br_state_e           state;
  br_entry_t           wentry, head;
  logic                acc_push, acc_res, head_miss, clear;
  logic                err_push, err_res;
  logic [XLEN_MAX-1:0] act_ext, rpc_nxt;

  assign act_ext = XLEN_MAX'(act_target);

  always_comb begin
    wentry          = '0;
    wentry.pred     = push_pred;
    wentry.target   = XLEN_MAX'(push_target);
    wentry.fallthru = XLEN_MAX'(push_fallthru);
  end

  assign acc_push  = push & ~stall & (state == RUN);
  assign acc_res   = resolve & ~stall & (count != '0);
  assign head_miss = br_miss(head, taken, act_ext);
  assign clear     = acc_res & head_miss;
  assign rpc_nxt   = taken ? act_ext : head.fallthru;

  // A push racing a mispredict is younger than the branch, so it is squashed, not an error.
  assign err_push  = acc_push & full & ~acc_res;
  assign err_res   = resolve & ~stall & (count == '0);

  br_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_push & ~clear),
    .pop   (acc_res),
    .clear (clear),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  generate
    if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^rpc_nxt[XLEN_MAX-1:XLEN];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      update      <= 1'b0;
      outcome     <= 1'b0;
      miss        <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      error       <= 1'b0;
    end else begin
      update <= acc_res;
      miss   <= clear;
      flush  <= clear;
      if (acc_res)            outcome     <= taken;
      if (clear)              redirect_pc <= rpc_nxt[XLEN-1:0];
      if (err_push | err_res) error       <= 1'b1;
      // RECOVER lasts exactly one cycle while the front end refetches.
      state <= (state == RUN && clear) ? RECOVER : RUN;
    end
  end

endmodule
